// File: rtl/adder_sum_accumulator_pkg.sv
// Shared types and limits for the windowed sum accumulator.
package adder_sum_accumulator_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam int WINDOW_MIN = 2;
  localparam int WINDOW_MAX = 32;
  localparam int ACC_W_MIN  = 8;
  localparam int ACC_W_MAX  = 16;
  localparam int IN_W       = 7;
  localparam int DROP_W     = 8;

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

endpackage

// File: rtl/adder_sum_accumulator_if.sv
// Sample input, window-result output and status signals of the accumulator.
interface adder_sum_accumulator_if #(
  parameter int ACC_W = 12
);
  import adder_sum_accumulator_pkg::*;

  logic              in_valid;
  logic [IN_W-1:0]   in_sum;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_overflow;
  logic              overrun;
  logic [DROP_W-1:0] drop_count;

  modport master (
    output in_valid, in_sum, clear, out_ready,
    input  out_valid, out_sum, out_overflow, overrun, drop_count
  );

  modport slave (
    input  in_valid, in_sum, clear, out_ready,
    output out_valid, out_sum, out_overflow, overrun, drop_count
  );

endinterface

// File: rtl/adder_sum_accumulator_sat_add.sv
// Unsigned adder clamping to all-ones, reporting when the clamp engaged.
module sat_add #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         sat
);

  function automatic logic [W-1:0] saturate(input logic [W:0] full);
    return full[W] ? {W{1'b1}} : full[W-1:0];
  endfunction

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign sat  = full[W];
  assign sum  = saturate(full);

endmodule

// File: rtl/adder_sum_accumulator.sv
// Accumulates WINDOW input sums, then hands the saturated total to a
// single-entry result register; results arriving while it is still full are dropped.
module adder_sum_accumulator
  import adder_sum_accumulator_pkg::*;
#(
  parameter int WINDOW = 4,
  parameter int ACC_W  = 12
) (
  input logic                    clk,
  input logic                    reset,
  adder_sum_accumulator_if.slave bus
);

  localparam int CNT_W = $clog2(WINDOW + 1);

  if (WINDOW < WINDOW_MIN || WINDOW > WINDOW_MAX) begin : g_window_check
    $error("adder_sum_accumulator: WINDOW out of legal range");
  end
  if (ACC_W < ACC_W_MIN || ACC_W > ACC_W_MAX) begin : g_acc_w_check
    $error("adder_sum_accumulator: ACC_W out of legal range");
  end

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc, acc_nxt, acc_base, add_sum, sample;
  logic [CNT_W-1:0]  count, count_nxt, count_base;
  logic              ovf, ovf_nxt, ovf_base, add_sat;
  logic              restart, complete, load, drop;
  logic              hold_valid, hold_ovf, overrun_flag;
  logic [ACC_W-1:0]  hold_sum;
  logic [DROP_W-1:0] drops;

  // The DONE cycle and clear both start a fresh window, yet a sample in that
  // same cycle still counts as sample 1, so restart selects the add base.
  assign restart    = (state == DONE) || bus.clear;
  assign acc_base   = restart ? '0 : acc;
  assign count_base = restart ? '0 : count;
  assign ovf_base   = restart ? 1'b0 : ovf;
  assign sample     = {{(ACC_W - IN_W){1'b0}}, bus.in_sum};

  sat_add #(.W(ACC_W)) u_sat_add (
    .a   (acc_base),
    .b   (sample),
    .sum (add_sum),
    .sat (add_sat)
  );

  always_comb begin
    state_nxt = ACCUM;
    acc_nxt   = acc_base;
    count_nxt = count_base;
    ovf_nxt   = ovf_base;
    complete  = 1'b0;
    if (bus.in_valid) begin
      acc_nxt   = add_sum;
      count_nxt = count_base + CNT_W'(1);
      ovf_nxt   = ovf_base | add_sat;
      complete  = !bus.clear && (count_nxt == CNT_W'(WINDOW));
    end
    if (complete) state_nxt = DONE;
    load = complete && (!hold_valid || bus.out_ready);
    drop = complete && hold_valid && !bus.out_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ACCUM;
    else       state <= state_nxt;
  end

  // Window accumulation stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      acc   <= acc_nxt;
      count <= count_nxt;
      ovf   <= ovf_nxt;
    end
  end

  // Result register and drop bookkeeping stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid   <= 1'b0;
      hold_sum     <= '0;
      hold_ovf     <= 1'b0;
      overrun_flag <= 1'b0;
      drops        <= '0;
    end else begin
      if (load) begin
        hold_valid <= 1'b1;
        hold_sum   <= acc_nxt;
        hold_ovf   <= ovf_nxt;
      end else if (bus.out_ready) begin
        hold_valid <= 1'b0;
      end
      if (drop) overrun_flag <= 1'b1;
      if (drop && drops != DROP_MAX) drops <= drops + DROP_W'(1);
    end
  end

  assign bus.out_valid    = hold_valid;
  assign bus.out_sum      = hold_sum;
  assign bus.out_overflow = hold_ovf;
  assign bus.overrun      = overrun_flag;
  assign bus.drop_count   = drops;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Directed vector table plus hand-written reset and saturation sequences.
module tb_adder_sum_accumulator;
  import adder_sum_accumulator_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  adder_sum_accumulator_if #(.ACC_W(12)) bus ();
  adder_sum_accumulator_if #(.ACC_W(8))  bus8 ();

  adder_sum_accumulator #(.WINDOW(4), .ACC_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  adder_sum_accumulator #(.WINDOW(4), .ACC_W(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  typedef struct {
    logic       v;
    logic [6:0] s;
    logic       clr;
    logic       rdy;
    logic       ev;
    int         esum;
    logic       eovf;
    logic       erun;
    int         edrop;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic row(input logic v, input int s, input logic clr, input logic rdy,
                     input logic ev, input int esum, input logic eovf,
                     input logic erun, input int edrop);
    vec_t r;
    r.v = v; r.s = 7'(s); r.clr = clr; r.rdy = rdy;
    r.ev = ev; r.esum = esum; r.eovf = eovf; r.erun = erun; r.edrop = edrop;
    tbl.push_back(r);
  endtask

  task automatic drive(input logic v, input int s, input logic clr, input logic rdy);
    bus.in_valid  = v;
    bus.in_sum    = 7'(s);
    bus.clear     = clr;
    bus.out_ready = rdy;
  endtask

  task automatic chk_all(input string tag, input logic ev, input int esum,
                         input logic eovf, input logic erun, input int edrop);
    chk({tag, " out_valid"},    int'(bus.out_valid),    int'(ev));
    chk({tag, " out_sum"},      int'(bus.out_sum),      esum);
    chk({tag, " out_overflow"}, int'(bus.out_overflow), int'(eovf));
    chk({tag, " overrun"},      int'(bus.overrun),      int'(erun));
    chk({tag, " drop_count"},   int'(bus.drop_count),   edrop);
  endtask

  initial begin
    drive(0, 0, 0, 1);
    bus8.in_valid = 0; bus8.in_sum = '0; bus8.clear = 0; bus8.out_ready = 1;

    // window 10+20+30+40 with consumer ready
    row(1,10,0,1, 0,0,0,0,0);
    row(1,20,0,1, 0,0,0,0,0);
    row(1,30,0,1, 0,0,0,0,0);
    row(1,40,0,1, 1,100,0,0,0);
    row(0,0,0,1,  0,100,0,0,0);
    // two windows of 1s with consumer stalled
    for (int k = 0; k < 3; k++) row(1,1,0,0, 0,100,0,0,0);
    row(1,1,0,0, 1,4,0,0,0);
    for (int k = 0; k < 3; k++) row(1,1,0,0, 1,4,0,0,0);
    row(1,1,0,0, 1,4,0,1,1);
    row(0,0,0,0, 1,4,0,1,1);
    row(0,0,0,1, 0,4,0,1,1);
    // 5,5 then clear with a sample of 1, then 1,1,1
    row(1,5,0,1, 0,4,0,1,1);
    row(1,5,0,1, 0,4,0,1,1);
    row(1,1,1,1, 0,4,0,1,1);
    row(1,1,0,1, 0,4,0,1,1);
    row(1,1,0,1, 0,4,0,1,1);
    row(1,1,0,1, 1,4,0,1,1);
    row(0,0,0,1, 0,4,0,1,1);
    // gapped 2s held, then gapped 3s completing on a handshake
    row(1,2,0,0, 0,4,0,1,1);
    row(0,0,0,0, 0,4,0,1,1);
    row(1,2,0,0, 0,4,0,1,1);
    row(1,2,0,0, 0,4,0,1,1);
    row(0,0,0,0, 0,4,0,1,1);
    row(1,2,0,0, 1,8,0,1,1);
    row(1,3,0,0, 1,8,0,1,1);
    row(0,0,0,0, 1,8,0,1,1);
    row(1,3,0,0, 1,8,0,1,1);
    row(0,0,0,0, 1,8,0,1,1);
    row(1,3,0,0, 1,8,0,1,1);
    row(0,0,0,0, 1,8,0,1,1);
    row(1,3,0,1, 1,12,0,1,1);
    row(0,0,0,1, 0,12,0,1,1);
    // clear coinciding with the 4th sample suppresses that result
    for (int k = 0; k < 3; k++) row(1,1,0,1, 0,12,0,1,1);
    row(1,1,1,1, 0,12,0,1,1);
    row(1,1,0,1, 0,12,0,1,1);
    row(1,1,0,1, 0,12,0,1,1);
    row(1,1,0,1, 1,4,0,1,1);
    row(0,0,0,1, 0,4,0,1,1);

    #2;
    chk_all("reset", 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, int'(tbl[i].s), tbl[i].clr, tbl[i].rdy);
      tick();
      chk_all($sformatf("row%0d", i), tbl[i].ev, tbl[i].esum, tbl[i].eovf,
              tbl[i].erun, tbl[i].edrop);
    end
    drive(0, 0, 0, 1);

    // ACC_W=8: 4 x 127 saturates, next window of 1s is clean
    for (int k = 0; k < 4; k++) begin
      bus8.in_valid = 1; bus8.in_sum = 7'd127;
      tick();
    end
    chk("sat8 out_valid",    int'(bus8.out_valid),    1);
    chk("sat8 out_sum",      int'(bus8.out_sum),      255);
    chk("sat8 out_overflow", int'(bus8.out_overflow), 1);
    for (int k = 0; k < 4; k++) begin
      bus8.in_valid = 1; bus8.in_sum = 7'd1;
      tick();
    end
    bus8.in_valid = 0;
    chk("clean8 out_valid",    int'(bus8.out_valid),    1);
    chk("clean8 out_sum",      int'(bus8.out_sum),      4);
    chk("clean8 out_overflow", int'(bus8.out_overflow), 0);
    chk("clean8 overrun",      int'(bus8.overrun),      0);

    // 9,9 then reset mid-window, then 2,2,2,2
    drive(1, 9, 0, 1); tick();
    drive(1, 9, 0, 1); tick();
    drive(0, 0, 0, 1);
    reset = 1;
    #1;
    chk_all("midreset", 0, 0, 0, 0, 0);
    tick();
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 2, 0, 1); tick();
      chk($sformatf("postreset%0d out_valid", k), int'(bus.out_valid), 0);
    end
    drive(1, 2, 0, 1); tick();
    drive(0, 0, 0, 1);
    chk_all("postreset done", 1, 8, 0, 0, 0);
    tick();
    chk("postreset consumed", int'(bus.out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_sum_accumulator.md
ADDER_SUM_ACCUMULATOR -- requirements
Module: adder_sum_accumulator

Interface
REQ-001 Parameter WINDOW, default 4: samples per accumulation window; legal range 2..32.
REQ-002 Parameter ACC_W, default 12: accumulator and result width; legal range 8..16.
REQ-003 Port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1: in_sum is valid this cycle; no backpressure upstream, so the block always accepts it.
REQ-006 Port in_sum, input, 7: unsigned sum from the upstream adder stage.
REQ-007 Port clear, input, 1: synchronous restart of the current window.
REQ-008 Port out_valid, output, 1: result register holds an unconsumed result.
REQ-009 Port out_ready, input, 1: consumer accepts the result.
REQ-010 Port out_sum, output, ACC_W: completed window total.
REQ-011 Port out_overflow, output, 1: out_sum saturated during its window.
REQ-012 Port overrun, output, 1: sticky flag; a completed window was dropped.
REQ-013 Port drop_count, output, 8: number of dropped windows; saturates at 255.

Function
REQ-014 The block SHALL be a two-state FSM: ACCUM (collecting) and DONE (window complete for one cycle).
- ACCUM goes to DONE when the accepted sample brings count to WINDOW.
- DONE always returns to ACCUM.
REQ-015 Each in_valid cycle SHALL add zero-extended in_sum to acc and increment count; cycles with in_valid=0 SHALL change neither.
REQ-016 Addition SHALL saturate at 2^ACC_W-1, and any saturation SHALL set a per-window overflow flag.
REQ-017 In the DONE cycle the block SHALL:
- clear acc, count and the overflow flag;
- still accumulate a sample arriving in that cycle as sample 1 of the next window.
REQ-018 A result SHALL be presented with out_valid high on the cycle after the WINDOW-th sample is accepted, which gives a latency of 1 cycle.
REQ-019 On a window completion, the result SHALL load into the output register when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle (no overrun in the latter case).
REQ-020 On a window completion with out_valid=1 and out_ready=0, the block SHALL:
- keep the held result unchanged;
- discard the new result;
- set overrun;
- increment drop_count.
REQ-021 out_valid SHALL fall after an out_ready=1 handshake, unless a new result loads in the same cycle.
REQ-022 out_sum and out_overflow SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 clear SHALL zero acc, count and the overflow flag, and return the FSM to ACCUM.
- A sample arriving in the clear cycle SHALL become sample 1 of the new window.
- clear SHALL NOT affect the output register, overrun or drop_count.
REQ-024 clear coinciding with window completion SHALL suppress that result.
REQ-025 overrun and drop_count SHALL clear only on reset.

Reset
REQ-026 On reset the block SHALL immediately set acc=0, count=0, state=ACCUM, out_valid=0, out_sum=0, out_overflow=0, overrun=0 and drop_count=0.
REQ-027 Reset mid-window SHALL discard the partial window, and the first in_valid after reset deasserts SHALL be sample 1.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the WINDOW/ACC_W legal-range constants and the drop_count width (8).
REQ-029 Saturating addition SHALL be a sub-module sat_add, parameterised by width, that returns the sum and a saturation flag.
REQ-030 All other logic SHALL reside in adder_sum_accumulator, and parameter range checks SHALL be elaboration-time assertions.

Verification (WINDOW=4 and ACC_W=12 unless stated otherwise)
REQ-031 Samples 10,20,30,40 on consecutive cycles with out_ready=1 -> out_valid for 1 cycle, out_sum=100, out_overflow=0.
REQ-032 ACC_W=8 with four samples of 127 -> out_sum=255, out_overflow=1.
REQ-033 out_ready=0 and two full windows of 1s -> out_sum=4 held, overrun=1, drop_count=1; then out_ready=1 -> out_valid falls next cycle.
REQ-034 Samples 5,5, then clear with a simultaneous sample of 1, then 1,1,1 -> out_sum=4.
REQ-035 Samples 9,9, reset pulse, then 2,2,2,2 -> all outputs 0 during reset, then out_sum=8.
REQ-036 Samples 3 separated by random in_valid gaps, with window completion coinciding with an out_ready handshake -> out_sum=12 and no overrun.
